adder_nibble_seq: RTL and testbench



---
 rtl/adder_nibble_seq_pkg.sv | 23 ++
 rtl/adder_nibble_seq_if.sv | 27 ++
 rtl/adder_4bit.sv | 16 +
 rtl/adder_nibble_seq.sv | 117 +++++++++++
 tb/tb_adder_nibble_seq.sv | 232 +++++++++++++++++++++++
 5 files changed

// File: rtl/adder_nibble_seq_pkg.sv
// Shared definitions for the nibble-serial adder: FSM state encodings and
// the nibble width of the shared 4-bit datapath.
package adder_nibble_seq_pkg;

    localparam int NIBBLE_W = 4;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_e;

    // Number of adder passes needed for an operand of the given width.
    function automatic int nibble_count(input int width);
        return width / NIBBLE_W;
    endfunction

    // An operand width is usable only if it splits into whole nibbles.
    function automatic bit width_ok(input int width);
        return (width >= NIBBLE_W) && ((width % NIBBLE_W) == 0);
    endfunction

endpackage

// File: rtl/adder_nibble_seq_if.sv
// Operand/result handshake bundle between an operand source (master) and
// the nibble-serial adder (slave).
interface adder_nibble_seq_if #(
    parameter int WIDTH = 16
) ();

    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             cin;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] sum;
    logic             cout;

    modport master (
        output in_valid, a, b, cin, out_ready,
        input  in_ready, out_valid, sum, cout
    );

    modport slave (
        input  in_valid, a, b, cin, out_ready,
        output in_ready, out_valid, sum, cout
    );

endinterface

// File: rtl/adder_4bit.sv
// Existing 4-bit ripple adder shared by the nibble-serial controller.
module adder_4bit (
    input  logic [3:0] a,
    input  logic [3:0] b,
    input  logic       cin,
    output logic [3:0] sum,
    output logic       cout
);

    logic [4:0] full;

    assign full = {1'b0, a} + {1'b0, b} + {4'b0000, cin};
    assign sum  = full[3:0];
    assign cout = full[4];

endmodule

// File: rtl/adder_nibble_seq.sv
// Multi-precision adder: computes a+b+cin over WIDTH bits by running one
// shared adder_4bit over the operand nibbles, LSB first, carry chained.
module adder_nibble_seq
    import adder_nibble_seq_pkg::*;
#(
    parameter int WIDTH = 16
) (
    input  logic               clk,
    input  logic               rst_n,
    adder_nibble_seq_if.slave  bus,
    output logic               busy
);

    localparam int NIBBLES = nibble_count(WIDTH);
    localparam int CNT_W   = (NIBBLES > 1) ? $clog2(NIBBLES) : 1;
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(NIBBLES - 1);

    generate
        if (!width_ok(WIDTH)) begin : g_bad_width
            $error("adder_nibble_seq: WIDTH must be a multiple of 4 and >= 4");
        end
    endgenerate

    // Drop the oldest result nibble off the bottom, insert the new one at the top.
    function automatic logic [WIDTH-1:0] shift_in(
        input logic [WIDTH-1:0]    acc,
        input logic [NIBBLE_W-1:0] nib
    );
        return (acc >> NIBBLE_W) | (WIDTH'(nib) << (WIDTH - NIBBLE_W));
    endfunction

    state_e               state_q;
    state_e               state_d;
    logic [CNT_W-1:0]     count_q;
    logic                 carry_q;
    logic [WIDTH-1:0]     a_sh_q;
    logic [WIDTH-1:0]     b_sh_q;
    logic [WIDTH-1:0]     res_sh_q;
    logic [WIDTH-1:0]     sum_q;
    logic                 cout_q;

    logic [NIBBLE_W-1:0]  nib_sum;
    logic                 nib_cout;
    logic                 accept;
    logic                 last_pass;
    logic [WIDTH-1:0]     res_next;

    adder_4bit u_adder (
        .a    (a_sh_q[NIBBLE_W-1:0]),
        .b    (b_sh_q[NIBBLE_W-1:0]),
        .cin  (carry_q),
        .sum  (nib_sum),
        .cout (nib_cout)
    );

    assign accept    = (state_q == ST_IDLE) && bus.in_valid;
    assign last_pass = (state_q == ST_RUN) && (count_q == LAST_CNT);
    assign res_next  = shift_in(res_sh_q, nib_sum);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            ST_IDLE: if (bus.in_valid)  state_d = ST_RUN;
            ST_RUN:  if (last_pass)     state_d = ST_DONE;
            ST_DONE: if (bus.out_ready) state_d = ST_IDLE;
            default:                    state_d = ST_IDLE;
        endcase
    end

    // Operands enter only on accept, so X on idle inputs never reaches the datapath.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            count_q  <= '0;
            carry_q  <= 1'b0;
            a_sh_q   <= '0;
            b_sh_q   <= '0;
            res_sh_q <= '0;
        end else if (accept) begin
            count_q  <= '0;
            carry_q  <= bus.cin;
            a_sh_q   <= bus.a;
            b_sh_q   <= bus.b;
        end else if (state_q == ST_RUN) begin
            count_q  <= count_q + CNT_W'(1);
            carry_q  <= nib_cout;
            a_sh_q   <= a_sh_q >> NIBBLE_W;
            b_sh_q   <= b_sh_q >> NIBBLE_W;
            res_sh_q <= res_next;
        end
    end

    // Published result changes only on the final pass, so it holds across the handshake.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            sum_q  <= '0;
            cout_q <= 1'b0;
        end else if (last_pass) begin
            sum_q  <= res_next;
            cout_q <= nib_cout;
        end
    end

    assign bus.in_ready  = (state_q == ST_IDLE);
    assign bus.out_valid = (state_q == ST_DONE);
    assign bus.sum       = sum_q;
    assign bus.cout      = cout_q;
    assign busy          = (state_q != ST_IDLE);

endmodule

// File: tb/tb_adder_nibble_seq.sv
// Scoreboard bench for adder_nibble_seq at WIDTH=16: directed cases,
// backpressure, mid-operation reset and a randomised run with output stalls.
module tb_adder_nibble_seq;

    localparam int W = 16;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    logic busy;

    always #5 clk = ~clk;

    adder_nibble_seq_if #(.WIDTH(W)) bus ();

    logic         in_valid_d = 1'b0;
    logic [W-1:0] a_d        = '0;
    logic [W-1:0] b_d        = '0;
    logic         cin_d      = 1'b0;
    logic         ready_dir  = 1'b1;
    logic         rand_or    = 1'b1;
    logic         rand_stall = 1'b0;

    assign bus.in_valid  = in_valid_d;
    assign bus.a         = a_d;
    assign bus.b         = b_d;
    assign bus.cin       = cin_d;
    assign bus.out_ready = rand_stall ? rand_or : ready_dir;

    adder_nibble_seq #(.WIDTH(W)) u_dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus.slave),
        .busy  (busy)
    );

    int         n_tests = 0;
    int         n_fail  = 0;
    logic [W:0] sb[$];

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        if (obs !== exp) begin
            n_fail++;
            $display("[TB] FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic send(input logic [W-1:0] a, input logic [W-1:0] b, input logic c);
        int t = 0;
        while (!bus.in_ready && t < 100) begin
            step();
            t++;
        end
        if (!bus.in_ready) begin
            check("send_timeout", 32'(bus.in_ready), 32'd1);
        end else begin
            in_valid_d = 1'b1;
            a_d        = a;
            b_d        = b;
            cin_d      = c;
            sb.push_back({1'b0, a} + {1'b0, b} + {{W{1'b0}}, c});
            step();
            in_valid_d = 1'b0;
            a_d        = 'x;
            b_d        = 'x;
            cin_d      = 'x;
        end
    endtask

    task automatic drain();
        int t = 0;
        while (sb.size() != 0 && t < 300) begin
            step();
            t++;
        end
        if (sb.size() != 0) begin
            check("drain_timeout", 32'(sb.size()), 32'd0);
            sb.delete();
        end
        step();
    endtask

    // Result monitor: compares at the falling edge preceding a handshake edge.
    always @(negedge clk) begin
        logic [W:0] exp;
        if (rst_n && bus.out_valid && bus.out_ready) begin
            if (sb.size() == 0) begin
                check("unexpected_result", 32'd1, 32'd0);
            end else begin
                exp = sb.pop_front();
                check("sum",  32'(bus.sum),  32'(exp[W-1:0]));
                check("cout", 32'(bus.cout), 32'(exp[W]));
            end
        end
    end

    always @(posedge clk) begin
        #1;
        rand_or = 1'($urandom_range(0, 1));
    end

    initial begin
        #2_000_000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic         bad;
        logic [W-1:0] ra;
        logic [W-1:0] rb;
        int           t;

        // Reset held with in_valid asserted: reset must win.
        rst_n      = 1'b0;
        in_valid_d = 1'b1;
        a_d        = 16'hABCD;
        b_d        = 16'h1111;
        step(); step(); step();
        check("rst_in_ready",  32'(bus.in_ready),  32'd1);
        check("rst_out_valid", 32'(bus.out_valid), 32'd0);
        check("rst_busy",      32'(busy),          32'd0);
        check("rst_sum",       32'(bus.sum),       32'd0);
        check("rst_cout",      32'(bus.cout),      32'd0);
        in_valid_d = 1'b0;
        a_d        = 'x;
        b_d        = 'x;
        cin_d      = 'x;
        rst_n      = 1'b1;
        step(); step();
        check("idle_busy", 32'(busy),    32'd0);
        check("idle_sum",  32'(bus.sum), 32'd0);

        // Latency: out_valid 4 cycles after accept, for exactly one cycle.
        ready_dir = 1'b1;
        send(16'h1234, 16'h4321, 1'b0);
        check("run_busy",     32'(busy),         32'd1);
        check("run_in_ready", 32'(bus.in_ready), 32'd0);
        bad = 1'b0;
        for (int k = 1; k <= 3; k++) begin
            step();
            if (bus.out_valid) bad = 1'b1;
        end
        check("early_valid", 32'(bad), 32'd0);
        step();
        check("lat4_valid", 32'(bus.out_valid), 32'd1);
        check("lat4_sum",   32'(bus.sum),       32'h5555);
        step();
        check("valid_one_cycle", 32'(bus.out_valid), 32'd0);
        check("hold_sum",        32'(bus.sum),       32'h5555);
        drain();

        // Carry ripples through all passes, then no stale carry.
        send(16'hFFFF, 16'h0000, 1'b1);
        drain();
        send(16'hFFFF, 16'hFFFF, 1'b1);
        drain();
        send(16'h0000, 16'h0000, 1'b0);
        drain();

        // Backpressure with new operands offered during DONE.
        ready_dir = 1'b0;
        send(16'h8001, 16'h8002, 1'b1);
        t = 0;
        while (!bus.out_valid && t < 20) begin
            step();
            t++;
        end
        check("bp_valid_rise", 32'(bus.out_valid), 32'd1);
        in_valid_d = 1'b1;
        a_d        = 16'h1111;
        b_d        = 16'h2222;
        cin_d      = 1'b0;
        for (int k = 0; k < 3; k++) begin
            step();
            check("bp_valid",    32'(bus.out_valid), 32'd1);
            check("bp_sum",      32'(bus.sum),       32'h0004);
            check("bp_cout",     32'(bus.cout),      32'd1);
            check("bp_in_ready", 32'(bus.in_ready),  32'd0);
        end
        ready_dir  = 1'b1;
        in_valid_d = 1'b0;
        step();
        check("bp_release_ready", 32'(bus.in_ready), 32'd1);
        check("bp_release_busy",  32'(busy),         32'd0);
        send(16'h1111, 16'h2222, 1'b0);
        drain();

        // Reset during RUN at count==2 discards the operation.
        send(16'hFFFF, 16'h0001, 1'b0);
        step();
        step();
        rst_n = 1'b0;
        sb.delete();
        step();
        rst_n = 1'b1;
        check("mid_rst_out_valid", 32'(bus.out_valid), 32'd0);
        check("mid_rst_in_ready",  32'(bus.in_ready),  32'd1);
        check("mid_rst_busy",      32'(busy),          32'd0);
        check("mid_rst_sum",       32'(bus.sum),       32'd0);
        check("mid_rst_cout",      32'(bus.cout),      32'd0);
        bad = 1'b0;
        for (int k = 0; k < 6; k++) begin
            step();
            if (bus.out_valid || busy) bad = 1'b1;
        end
        check("mid_rst_no_partial", 32'(bad), 32'd0);
        send(16'h0F0F, 16'h00F1, 1'b0);
        drain();

        // Random operands with random output stalls.
        rand_stall = 1'b1;
        for (int i = 0; i < 1000; i++) begin
            ra = W'($urandom);
            rb = W'($urandom);
            send(ra, rb, 1'($urandom_range(0, 1)));
        end
        drain();
        rand_stall = 1'b0;
        drain();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        if (n_fail != 0) $fatal(1, "adder_nibble_seq bench ended with errors");
        $finish;
    end

endmodule
